// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift/rotate unit: modes, FSM states
// and NZCV flag bit positions.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/result handshake bundle between the control path and the shift unit.
// Both channels are valid/ready: a transfer happens on a rising clock edge where
// valid && ready; the producer holds its payload stable while valid is high.
interface shift_unit_seq_if #(
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amount;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_data, in_amount, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_amount, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/shift_step.sv
// Combinational partial shift: moves data by k (0..STEP) bits in one mode and
// reports the last bit moved out (0 when k is 0).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  mode_e            mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);

    // Unrolled chain of single-bit moves; stage i is active only when i < k.
    always_comb begin
        data_o  = data_i;
        carry_o = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k_i)) begin
                case (mode_i)
                    MODE_LSL: begin
                        carry_o = data_o[WIDTH-1];
                        data_o  = {data_o[WIDTH-2:0], 1'b0};
                    end
                    MODE_LSR: begin
                        carry_o = data_o[0];
                        data_o  = {1'b0, data_o[WIDTH-1:1]};
                    end
                    MODE_ASR: begin
                        carry_o = data_o[0];
                        data_o  = {sign_i, data_o[WIDTH-1:1]};
                    end
                    MODE_ROR: begin
                        carry_o = data_o[0];
                        data_o  = {data_o[0], data_o[WIDTH-1:1]};
                    end
                    default: begin
                        carry_o = 1'b0;
                        data_o  = data_o;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: LSL/LSR/ASR/ROR at up to STEP bits per clock,
// producing a registered result with NZCV flags behind valid/ready handshakes.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    shift_unit_seq_if.slave  bus,
    output state_e           dbg_state
);

    localparam int KW = $clog2(STEP) + 1;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]       out_flags_q, out_flags_d;

    logic [AW-1:0]    eff;
    logic [KW-1:0]    step_k;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] d, input logic c);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = d[WIDTH-1];
        f[FLAG_Z] = (d == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = 1'b0;
        return f;
    endfunction

    // Shifts saturate one past WIDTH so the carry ends up 0; rotates reduce
    // modulo WIDTH but keep a full turn so the carry reflects the MSB.
    always_comb begin
        eff = '0;
        if (mode_e'(bus.in_mode) == MODE_ROR) begin
            eff = {1'b0, bus.in_amount[AW-2:0]};
            if ((bus.in_amount != '0) && (bus.in_amount[AW-2:0] == '0)) begin
                eff = AW'(WIDTH);
            end
        end else begin
            eff = (bus.in_amount > AW'(WIDTH + 1)) ? AW'(WIDTH + 1) : bus.in_amount;
        end
    end

    assign step_k = (rem_q > AW'(STEP)) ? KW'(STEP) : KW'(rem_q);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data_i  (work_q),
        .k_i     (step_k),
        .mode_i  (mode_q),
        .sign_i  (sign_q),
        .data_o  (step_data),
        .carry_o (step_carry)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        work_d      = work_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mode_d = mode_e'(bus.in_mode);
                    sign_d = bus.in_data[WIDTH-1];
                    work_d = bus.in_data;
                    rem_d  = eff;
                    if (eff == '0) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = bus.in_data;
                        out_flags_d = pack_flags(bus.in_data, 1'b0);
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                work_d = step_data;
                rem_d  = rem_q - AW'(step_k);
                if (rem_d == '0) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = step_data;
                    out_flags_d = pack_flags(step_data, step_carry);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_LSL;
            sign_q      <= 1'b0;
            work_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (WIDTH=32, STEP=4): results, flags,
// latency, backpressure and mid-operation reset.
module tb_shift_unit_seq;
    import shift_pkg::*;

    logic   clk;
    logic   reset;
    state_e dbg_state;
    int     checks;
    int     errors;

    shift_unit_seq_if #(.WIDTH(32), .AW(6)) bus ();

    shift_unit_seq #(
        .WIDTH (32),
        .STEP  (4),
        .AW    (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Runs one operation; hold > 0 keeps out_ready low that many cycles in DONE
    // while presenting a junk request that must be ignored.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [5:0] amt,
                          input logic [1:0] mode, input logic [31:0] exp_d,
                          input logic [3:0] exp_f, input int exp_lat, input int hold);
        int guard;
        int lat;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amount = amt;
        bus.in_mode   = mode;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, bus.out_data, exp_d);
        check({tag, "_flags"}, 32'(bus.out_flags), 32'(exp_f));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'hDEAD_BEEF;
            bus.in_amount = 6'd1;
            bus.in_mode   = 2'b01;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_data"}, bus.out_data, exp_d);
            check({tag, "_hold_flags"}, 32'(bus.out_flags), 32'(exp_f));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amount = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        run_op("lsl31",   32'h0000_0001, 6'd31, 2'b00, 32'h8000_0000, 4'b1000, 9,  0);
        run_op("asr40",   32'h8000_0000, 6'd40, 2'b10, 32'hFFFF_FFFF, 4'b1010, 10, 0);
        run_op("lsr32",   32'hFFFF_FFFF, 6'd32, 2'b01, 32'h0000_0000, 4'b0110, 9,  0);
        run_op("lsr33",   32'hFFFF_FFFF, 6'd33, 2'b01, 32'h0000_0000, 4'b0100, 10, 0);
        run_op("ror4",    32'hFFFF_0000, 6'd4,  2'b11, 32'h0FFF_F000, 4'b0000, 2,  0);
        run_op("ror32",   32'hFFFF_0000, 6'd32, 2'b11, 32'hFFFF_0000, 4'b1010, 9,  0);
        run_op("ror0",    32'hFFFF_0000, 6'd0,  2'b11, 32'hFFFF_0000, 4'b1000, 1,  0);
        run_op("ror33",   32'h0000_0001, 6'd33, 2'b11, 32'h8000_0000, 4'b1010, 2,  0);
        run_op("lsl1c",   32'h8000_0001, 6'd1,  2'b00, 32'h0000_0002, 4'b0010, 2,  0);
        run_op("asr30",   32'h4000_0000, 6'd30, 2'b10, 32'h0000_0001, 4'b0000, 9,  0);
        run_op("lsl0",    32'h0000_0000, 6'd0,  2'b00, 32'h0000_0000, 4'b0100, 1,  0);

        // Backpressure followed immediately by another operation
        run_op("bp",      32'h0000_0001, 6'd4,  2'b00, 32'h0000_0010, 4'b0000, 2,  5);
        run_op("b2b",     32'h0000_0080, 6'd3,  2'b01, 32'h0000_0010, 4'b0000, 2,  0);

        // Reset in the middle of a long LSL
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0001;
        bus.in_amount = 6'd20;
        bus.in_mode   = 2'b00;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("abort_busy", 32'(dbg_state), 32'(ST_BUSY));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_data", bus.out_data, 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(bus.out_valid), 32'd0);
        run_op("after_rst", 32'hF000_0000, 6'd4, 2'b01, 32'h0F00_0000, 4'b0000, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
